// File: rtl/rvvi_rx_cmd_parser.sv
// Streaming host-command parser on the MAC receive AXI-stream: checks the Ethernet
// header, decodes a 6-byte ASCII command plus optional argument, and acts at frame end.
module rvvi_rx_cmd_parser #(
   parameter logic [47:0] DST_MAC    = 48'h4502_1111_6843,
   parameter logic [15:0] ETHER_TYPE = 16'h005c,
   parameter logic [47:0] CMD_TRIG   = 48'h6e69_6769_7274,
   parameter logic [47:0] CMD_SLOW   = 48'h656D_776F_6C73,
   parameter logic [47:0] CMD_HALT   = 48'h656D_746C_6168,
   parameter logic [47:0] CMD_RESUME = 48'h656D_7573_6572
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] RvviAxiRdata,
   input  logic [3:0]  RvviAxiRstrb,
   input  logic        RvviAxiRvalid,
   input  logic        RvviAxiRlast,
   input  logic        RvviAxiRuser,
   output logic        IlaTrigger,
   output logic        HostRequestSlowDown,
   output logic [31:0] HostFiFoFillAmt,
   output logic        HaltReq,
   output logic [15:0] AcceptCount,
   output logic [15:0] DropCount
);

   typedef enum logic [2:0] {
      ST_HDR     = 3'd0,
      ST_CMD     = 3'd1,
      ST_ARG     = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_DISCARD = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      CM_TRIG   = 2'd0,
      CM_SLOW   = 2'd1,
      CM_HALT   = 2'd2,
      CM_RESUME = 2'd3
   } cmd_t;

   state_t      state_q, state_d, parse_state_s;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] cmd_lo_q, cmd_lo_d;
   cmd_t        cmd_q, cmd_d, cmd_dec_s, fire_cmd_s;
   logic [31:0] arg_q, arg_d, fire_arg_s;
   logic        ila_q, ila_d, slow_q, slow_d, halt_q, halt_d;
   logic [31:0] fill_q, fill_d;
   logic [15:0] acc_q, acc_d, drop_q, drop_d;
   logic        strb_ok_s, hdr_ok_s, cmd_hit_s, accept_s, drop_s;
   logic [47:0] cmd_word_s;

   // Per-beat header word check and command decode
   always_comb begin
      strb_ok_s  = (RvviAxiRstrb == 4'hF);
      cmd_word_s = {RvviAxiRdata, cmd_lo_q};
      case (idx_q)
         3'd0:    hdr_ok_s = strb_ok_s && (RvviAxiRdata == DST_MAC[31:0]);
         3'd1:    hdr_ok_s = strb_ok_s && (RvviAxiRdata[15:0] == DST_MAC[47:32]);
         3'd2:    hdr_ok_s = strb_ok_s;
         3'd3:    hdr_ok_s = strb_ok_s && (RvviAxiRdata[15:0] == ETHER_TYPE);
         default: hdr_ok_s = 1'b0;
      endcase
      cmd_hit_s = 1'b1;
      if (cmd_word_s == CMD_TRIG) begin
         cmd_dec_s = CM_TRIG;
      end else if (cmd_word_s == CMD_SLOW) begin
         cmd_dec_s = CM_SLOW;
      end else if (cmd_word_s == CMD_HALT) begin
         cmd_dec_s = CM_HALT;
      end else if (cmd_word_s == CMD_RESUME) begin
         cmd_dec_s = CM_RESUME;
      end else begin
         cmd_dec_s = CM_TRIG;
         cmd_hit_s = 1'b0;
      end
   end

   // Next-state logic; parse_state_s is where this beat leaves the frame before tlast forces HDR
   always_comb begin
      parse_state_s = state_q;
      state_d       = state_q;
      idx_d         = idx_q;
      cmd_lo_d      = cmd_lo_q;
      cmd_d         = cmd_q;
      arg_d         = arg_q;
      if (RvviAxiRvalid) begin
         idx_d = (idx_q == 3'd6) ? 3'd6 : idx_q + 3'd1;
         case (state_q)
            ST_HDR: begin
               if (!hdr_ok_s) begin
                  parse_state_s = ST_DISCARD;
               end else if (idx_q == 3'd3) begin
                  parse_state_s = ST_CMD;
                  cmd_lo_d      = RvviAxiRdata[31:16];
               end else begin
                  parse_state_s = ST_HDR;
               end
            end
            ST_CMD: begin
               if (strb_ok_s && cmd_hit_s) begin
                  cmd_d         = cmd_dec_s;
                  parse_state_s = (cmd_dec_s == CM_SLOW) ? ST_ARG : ST_DRAIN;
               end else begin
                  parse_state_s = ST_DISCARD;
               end
            end
            ST_ARG: begin
               if (strb_ok_s) begin
                  arg_d         = RvviAxiRdata;
                  parse_state_s = ST_DRAIN;
               end else begin
                  parse_state_s = ST_DISCARD;
               end
            end
            ST_DRAIN:   parse_state_s = ST_DRAIN;
            ST_DISCARD: parse_state_s = ST_DISCARD;
            default:    parse_state_s = ST_DISCARD;
         endcase
         if (RvviAxiRlast) begin
            state_d = ST_HDR;
            idx_d   = 3'd0;
         end else begin
            state_d = parse_state_s;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Frame-end actions; the command/argument may be completing on the tlast beat itself
   always_comb begin
      fire_cmd_s = (state_q == ST_CMD) ? cmd_dec_s : cmd_q;
      fire_arg_s = (state_q == ST_ARG) ? RvviAxiRdata : arg_q;
      accept_s   = RvviAxiRvalid && RvviAxiRlast && !RvviAxiRuser &&
                   (parse_state_s == ST_DRAIN);
      drop_s     = RvviAxiRvalid && RvviAxiRlast && !accept_s;
      ila_d      = 1'b0;
      slow_d     = 1'b0;
      fill_d     = fill_q;
      halt_d     = halt_q;
      acc_d      = acc_q;
      drop_d     = drop_q;
      if (accept_s) begin
         acc_d = (acc_q == 16'hFFFF) ? acc_q : acc_q + 16'd1;
         case (fire_cmd_s)
            CM_TRIG:   ila_d = 1'b1;
            CM_SLOW: begin
               slow_d = 1'b1;
               fill_d = fire_arg_s;
            end
            CM_HALT:   halt_d = 1'b1;
            CM_RESUME: halt_d = 1'b0;
            default:   halt_d = halt_q;
         endcase
      end else if (drop_s) begin
         drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_HDR;
      end else begin
         state_q <= state_d;
      end
   end

   // Parse holding registers, action outputs and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q    <= 3'd0;
         cmd_lo_q <= 16'd0;
         cmd_q    <= CM_TRIG;
         arg_q    <= 32'd0;
         ila_q    <= 1'b0;
         slow_q   <= 1'b0;
         fill_q   <= 32'd0;
         halt_q   <= 1'b0;
         acc_q    <= 16'd0;
         drop_q   <= 16'd0;
      end else begin
         idx_q    <= idx_d;
         cmd_lo_q <= cmd_lo_d;
         cmd_q    <= cmd_d;
         arg_q    <= arg_d;
         ila_q    <= ila_d;
         slow_q   <= slow_d;
         fill_q   <= fill_d;
         halt_q   <= halt_d;
         acc_q    <= acc_d;
         drop_q   <= drop_d;
      end
   end

   assign IlaTrigger          = ila_q;
   assign HostRequestSlowDown = slow_q;
   assign HostFiFoFillAmt     = fill_q;
   assign HaltReq             = halt_q;
   assign AcceptCount         = acc_q;
   assign DropCount           = drop_q;

endmodule

// File: tb/tb_rvvi_rx_cmd_parser.sv
// Directed bench for rvvi_rx_cmd_parser: hand-built frames, expected outputs
// sampled on the falling edge after each frame end.
module tb_rvvi_rx_cmd_parser;

   localparam logic [47:0] C_TRIG   = 48'h6e69_6769_7274;
   localparam logic [47:0] C_SLOW   = 48'h656D_776F_6C73;
   localparam logic [47:0] C_HALT   = 48'h656D_746C_6168;
   localparam logic [47:0] C_RESUME = 48'h656D_7573_6572;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] RvviAxiRdata = 32'd0;
   logic [3:0]  RvviAxiRstrb = 4'h0;
   logic        RvviAxiRvalid = 1'b0;
   logic        RvviAxiRlast = 1'b0;
   logic        RvviAxiRuser = 1'b0;
   logic        IlaTrigger;
   logic        HostRequestSlowDown;
   logic [31:0] HostFiFoFillAmt;
   logic        HaltReq;
   logic [15:0] AcceptCount;
   logic [15:0] DropCount;

   int errors = 0;
   int checks = 0;

   logic [31:0] frm [0:7];
   logic [3:0]  stb [0:7];

   rvvi_rx_cmd_parser dut (
      .clk(clk), .reset(reset),
      .RvviAxiRdata(RvviAxiRdata), .RvviAxiRstrb(RvviAxiRstrb),
      .RvviAxiRvalid(RvviAxiRvalid), .RvviAxiRlast(RvviAxiRlast),
      .RvviAxiRuser(RvviAxiRuser),
      .IlaTrigger(IlaTrigger), .HostRequestSlowDown(HostRequestSlowDown),
      .HostFiFoFillAmt(HostFiFoFillAmt), .HaltReq(HaltReq),
      .AcceptCount(AcceptCount), .DropCount(DropCount)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [31:0] d, input logic [3:0] s, input logic l, input logic u);
      RvviAxiRdata  = d;
      RvviAxiRstrb  = s;
      RvviAxiRvalid = 1'b1;
      RvviAxiRlast  = l;
      RvviAxiRuser  = u;
   endtask

   task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic l, input logic u);
      @(negedge clk);
      drive(d, s, l, u);
   endtask

   task automatic idle();
      @(negedge clk);
      RvviAxiRvalid = 1'b0;
      RvviAxiRlast  = 1'b0;
      RvviAxiRuser  = 1'b0;
      RvviAxiRdata  = 32'hxxxx_xxxx;
   endtask

   task automatic build(input logic [47:0] cmd, input logic [31:0] arg);
      frm[0] = 32'h1111_6843;
      frm[1] = 32'h1654_4502;
      frm[2] = 32'h8f54_0000;
      frm[3] = {cmd[15:0], 16'h005c};
      frm[4] = cmd[47:16];
      frm[5] = arg;
      frm[6] = 32'hdead_beef;
      frm[7] = 32'h0000_0000;
      for (int i = 0; i < 8; i++) stb[i] = 4'hF;
   endtask

   task automatic send_frame(input int n, input logic user, input logic gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && (i % 2 == 1)) idle();
         beat(frm[i], stb[i], (i == n - 1), user && (i == n - 1));
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (IlaTrigger !== 1'b0) begin errors++; $display("FAIL reset_ila got=%b exp=0", IlaTrigger); end
      checks++; if (HostRequestSlowDown !== 1'b0) begin errors++; $display("FAIL reset_slow got=%b exp=0", HostRequestSlowDown); end
      checks++; if (HostFiFoFillAmt !== 32'd0) begin errors++; $display("FAIL reset_fill got=%h exp=0", HostFiFoFillAmt); end
      checks++; if (HaltReq !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", HaltReq); end
      checks++; if (AcceptCount !== 16'd0 || DropCount !== 16'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", AcceptCount, DropCount); end
   endtask

   task automatic test_trigin();
      build(C_TRIG, 32'd0);
      send_frame(5, 1'b0, 1'b0);
      idle();
      checks++; if (IlaTrigger !== 1'b1) begin errors++; $display("FAIL trig_pulse got=%b exp=1", IlaTrigger); end
      checks++; if (AcceptCount !== 16'd1) begin errors++; $display("FAIL trig_acc got=%0d exp=1", AcceptCount); end
      checks++; if (DropCount !== 16'd0) begin errors++; $display("FAIL trig_drop got=%0d exp=0", DropCount); end
      idle();
      checks++; if (IlaTrigger !== 1'b0) begin errors++; $display("FAIL trig_one_cycle got=%b exp=0", IlaTrigger); end
   endtask

   task automatic test_slowme();
      build(C_SLOW, 32'h0000_0300);
      stb[7] = 4'h3;
      send_frame(8, 1'b0, 1'b1);
      checks++; if (HostRequestSlowDown !== 1'b0) begin errors++; $display("FAIL slow_early got=%b exp=0", HostRequestSlowDown); end
      idle();
      checks++; if (HostRequestSlowDown !== 1'b1) begin errors++; $display("FAIL slow_pulse got=%b exp=1", HostRequestSlowDown); end
      checks++; if (HostFiFoFillAmt !== 32'h0000_0300) begin errors++; $display("FAIL slow_fill got=%h exp=00000300", HostFiFoFillAmt); end
      checks++; if (AcceptCount !== 16'd2) begin errors++; $display("FAIL slow_acc got=%0d exp=2", AcceptCount); end
      idle();
      checks++; if (HostRequestSlowDown !== 1'b0 || HostFiFoFillAmt !== 32'h0000_0300) begin
         errors++; $display("FAIL slow_hold got=%b/%h exp=0/00000300", HostRequestSlowDown, HostFiFoFillAmt); end
   endtask

   task automatic test_slowme_noarg();
      build(C_SLOW, 32'h0000_0777);
      send_frame(5, 1'b0, 1'b0);
      idle();
      checks++; if (HostRequestSlowDown !== 1'b0) begin errors++; $display("FAIL noarg_pulse got=%b exp=0", HostRequestSlowDown); end
      checks++; if (DropCount !== 16'd1) begin errors++; $display("FAIL noarg_drop got=%0d exp=1", DropCount); end
      checks++; if (HostFiFoFillAmt !== 32'h0000_0300) begin errors++; $display("FAIL noarg_fill got=%h exp=00000300", HostFiFoFillAmt); end
      checks++; if (AcceptCount !== 16'd2) begin errors++; $display("FAIL noarg_acc got=%0d exp=2", AcceptCount); end
   endtask

   task automatic test_hdr_defects();
      logic [15:0] exp_drop;
      exp_drop = 16'd1;
      for (int k = 0; k < 5; k++) begin
         build(C_TRIG, 32'd0);
         case (k)
            0: frm[0] = 32'h1111_6844;
            1: frm[3] = 32'h7274_0800;
            2: ;
            3: stb[1] = 4'h7;
            default: frm[4] = 32'h6e69_6768;
         endcase
         send_frame(5, (k == 2), 1'b0);
         idle();
         exp_drop = exp_drop + 16'd1;
         checks++; if (IlaTrigger !== 1'b0) begin errors++; $display("FAIL defect%0d_ila got=%b exp=0", k, IlaTrigger); end
         checks++; if (DropCount !== exp_drop) begin errors++; $display("FAIL defect%0d_drop got=%0d exp=%0d", k, DropCount, exp_drop); end
      end
      checks++; if (AcceptCount !== 16'd2) begin errors++; $display("FAIL defect_acc got=%0d exp=2", AcceptCount); end
   endtask

   task automatic test_back_to_back();
      checks++; if (HaltReq !== 1'b0) begin errors++; $display("FAIL b2b_halt_pre got=%b exp=0", HaltReq); end
      build(C_HALT, 32'd0);
      send_frame(5, 1'b0, 1'b0);
      build(C_RESUME, 32'd0);
      @(negedge clk);
      checks++; if (HaltReq !== 1'b1) begin errors++; $display("FAIL b2b_halt_rise got=%b exp=1", HaltReq); end
      drive(frm[0], 4'hF, 1'b0, 1'b0);
      for (int i = 1; i < 4; i++) beat(frm[i], 4'hF, 1'b0, 1'b0);
      @(negedge clk);
      checks++; if (HaltReq !== 1'b1) begin errors++; $display("FAIL b2b_halt_hold got=%b exp=1", HaltReq); end
      drive(frm[4], 4'hF, 1'b1, 1'b0);
      build(C_TRIG, 32'd0);
      @(negedge clk);
      checks++; if (HaltReq !== 1'b0) begin errors++; $display("FAIL b2b_halt_fall got=%b exp=0", HaltReq); end
      checks++; if (AcceptCount !== 16'd4) begin errors++; $display("FAIL b2b_acc got=%0d exp=4", AcceptCount); end
      drive(frm[0], 4'hF, 1'b0, 1'b0);
      for (int i = 1; i < 5; i++) beat(frm[i], 4'hF, (i == 4), 1'b0);
      @(negedge clk);
      checks++; if (IlaTrigger !== 1'b1) begin errors++; $display("FAIL b2b_trig1 got=%b exp=1", IlaTrigger); end
      drive(frm[0], 4'hF, 1'b0, 1'b0);
      for (int i = 1; i < 5; i++) beat(frm[i], 4'hF, (i == 4), 1'b0);
      idle();
      checks++; if (IlaTrigger !== 1'b1 || AcceptCount !== 16'd6) begin
         errors++; $display("FAIL b2b_trig2 got=%b/%0d exp=1/6", IlaTrigger, AcceptCount); end
   endtask

   task automatic test_reset_abort();
      build(C_TRIG, 32'd0);
      beat(frm[0], 4'hF, 1'b0, 1'b0);
      beat(frm[1], 4'hF, 1'b0, 1'b0);
      beat(frm[2], 4'hF, 1'b0, 1'b0);
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (AcceptCount !== 16'd0 || DropCount !== 16'd0 || IlaTrigger !== 1'b0) begin
         errors++; $display("FAIL abort_cleared got=%0d/%0d/%b exp=0/0/0", AcceptCount, DropCount, IlaTrigger); end
      drive(frm[3], 4'hF, 1'b0, 1'b0);
      beat(frm[4], 4'hF, 1'b1, 1'b0);
      idle();
      checks++; if (IlaTrigger !== 1'b0 || DropCount !== 16'd1) begin
         errors++; $display("FAIL abort_remainder got=%b/%0d exp=0/1", IlaTrigger, DropCount); end
      send_frame(5, 1'b0, 1'b0);
      idle();
      checks++; if (IlaTrigger !== 1'b1 || AcceptCount !== 16'd1) begin
         errors++; $display("FAIL abort_clean got=%b/%0d exp=1/1", IlaTrigger, AcceptCount); end
   endtask

   initial begin
      test_reset();
      test_trigin();
      test_slowme();
      test_slowme_noarg();
      test_hdr_defects();
      test_back_to_back();
      test_reset_abort();
      repeat (2) idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
